// File: rtl/clock_divider_mc.sv
// clock_divider_mc: multi-channel programmable 50%-duty clock divider and tick generator.
module clock_divider_mc #(
  parameter int NCH = 4,
  parameter int WIDTH = 32,
  parameter int DEFAULT_DIV = 100,
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  output logic [NCH-1:0]   div_clk,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);
  logic [WIDTH-1:0] cnt_q [NCH];
  logic [WIDTH-1:0] cnt_d [NCH];
  logic [WIDTH-1:0] act_q [NCH];
  logic [WIDTH-1:0] act_d [NCH];
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [NCH-1:0] div_clk_q, div_clk_d, tick_q, tick_d, pending_q, pending_d;
  logic [NCH-1:0] term, apply, wr;
  // A pending divisor is applied on sync, while disabled, or at terminal; a same-cycle write re-arms pending.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      term[i] = en[i] && cnt_q[i] >= act_q[i];
      apply[i] = sync || !en[i] || term[i];
      wr[i] = cfg_we && cfg_ch == CW'(i);
      cnt_d[i] = (sync || term[i]) ? '0 : en[i] ? cnt_q[i] + 1'b1 : cnt_q[i];
      div_clk_d[i] = sync ? 1'b0 : term[i] ? ~div_clk_q[i] : div_clk_q[i];
      tick_d[i] = !sync && term[i];
      act_d[i] = (apply[i] && pending_q[i]) ? shadow_q[i] : act_q[i];
      shadow_d[i] = wr[i] ? cfg_div : shadow_q[i];
      pending_d[i] = wr[i] || (pending_q[i] && !apply[i]);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= WIDTH'(DEFAULT_DIV);
        shadow_q[i] <= WIDTH'(DEFAULT_DIV);
      end
      div_clk_q <= '0;
      tick_q <= '0;
      pending_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      shadow_q <= shadow_d;
      div_clk_q <= div_clk_d;
      tick_q <= tick_d;
      pending_q <= pending_d;
    end
  end
  assign div_clk = div_clk_q;
  assign tick = tick_q;
  assign pending = pending_q;
endmodule
